spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- SPI master shift engine that sits between the TX and RX spiFifo instances of the SPI peripheral.
- It is the reader of the TX FIFO: it pops bytes and shifts them out on MOSI.
- It is the writer of the RX FIFO: it pushes each byte captured from MISO.
- It generates SCLK and the active-low slave select, and keeps slave select asserted across back-to-back bytes.

Parameters:
- DATAWIDTH, 8, bits per SPI frame and width of both FIFO data ports.
- DIVWIDTH, 8, width of the clkDiv configuration input.

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- enable  input  1  engine may start new frames while high.
- cpol  input  1  SCLK idle level.
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge.
- clkDiv  input  DIVWIDTH  SCLK half-period is (clkDiv+1) clk cycles.
- txEmpty  input  1  TX FIFO empty flag.
- txData  input  DATAWIDTH  TX FIFO head data.
- txReadReq  output  1  one-cycle TX FIFO pop.
- rxFull  input  1  RX FIFO full flag (count == depth-1).
- rxWriteEn  output  1  one-cycle RX FIFO push.
- rxData  output  DATAWIDTH  byte pushed to the RX FIFO.
- sclk  output  1  SPI clock.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in, MSB first.
- ssN  output  1  slave select, active low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-low; all outputs are registered.
- Reset values: sclk=0, mosi=0, ssN=1, busy=0, txReadReq=0, rxWriteEn=0, rxData=0, state=IDLE, divider=0, bitCount=0.
- FIFO contract: txData is valid for the head entry from the second cycle after txEmpty falls or after a pop. LOAD provides this margin.
- States:
  - IDLE: sclk follows cpol. Move to LOAD when enable && !txEmpty && !rxFull. cpol, cpha and clkDiv are latched on this transition and are ignored for the rest of the burst.
  - LOAD (1 cycle): shiftReg <= txData; txReadReq=1 for exactly this cycle; ssN<=0; mosi<=txData[MSB]. Next state is LEAD when ssN was high, SHIFT when continuing a burst.
  - LEAD: wait one half-period (setup time), then go to SHIFT.
  - SHIFT: the divider reloads with clkDiv and emits a tick on reaching 0. Each tick toggles sclk, giving 2*DATAWIDTH edges per frame.
    - cpha=0: sample miso on odd edges (1,3,..); shift and drive the next mosi bit on even edges. Skip the shift on the final edge.
    - cpha=1: drive mosi on odd edges; sample on even edges.
    - After edge 2*DATAWIDTH, sclk equals the latched cpol. Go to PUSH.
  - PUSH (1 cycle): rxData <= captured byte; rxWriteEn=1 for exactly this cycle.
    - If enable && !txEmpty && !rxFull: go to LOAD; ssN stays low.
    - Otherwise: go to TRAIL.
  - TRAIL: hold ssN low for one half-period, then ssN<=1 and go to IDLE.
- Throughput: back-to-back frames add 2 clk gaps (PUSH, LOAD), during which sclk holds idle. There is no extra ssN pulse between frames.
- The RX FIFO cannot overflow:
  - rxFull is checked before each frame starts.
  - The engine is the sole RX writer, so the RX count cannot rise during a frame.
  - rxWriteEn is never asserted while rxFull=1.
- txReadReq is never asserted while txEmpty=1.
- enable falling mid-frame: the current frame completes and is pushed, then the engine goes to TRAIL.
- resetN low mid-frame: immediate return to reset values. The partial frame is discarded with no push.
- bitCount and divider wrap only through explicit reload; clkDiv=0 gives an SCLK period of 2 clk.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LOAD, LEAD, SHIFT, PUSH, TRAIL);
  - the SPI mode constants (MODE0..MODE3 as {cpol,cpha});
  - the DATAWIDTH default.
- One sub-module, spi_clk_divider: reload counter with load/enable inputs and a tick output. The FSM and shifter stay in the top.

Test Plan:
- Mode 0, clkDiv=1, TX FIFO = {0xA5}, miso looped to mosi:
  - one txReadReq;
  - ssN low, then 8 sclk pulses of period 4 clk;
  - one rxWriteEn with rxData=0xA5;
  - ssN high after TRAIL; busy low.
- Burst: TX = {0x01,0x80,0xFF} in mode 3, slave model returns {0x3C,0xC3,0x5A}:
  - ssN is continuously low for all 24 pulses;
  - sclk idles high;
  - RX receives 0x3C,0xC3,0x5A in order.
- RX back-pressure: rxFull=1 with TX non-empty:
  - no txReadReq, ssN stays 1;
  - after rxFull falls, the frame starts within 2 cycles.
- Mid-burst stall: rxFull rises during frame 1 of 2:
  - frame 1 is pushed;
  - ssN deasserts via TRAIL;
  - frame 2 waits for !rxFull, then runs as a new burst starting with LEAD.
- Reset mid-frame: resetN pulled low after edge 5:
  - outputs immediately at reset values;
  - no rxWriteEn;
  - the next enabled frame is correct (0x5A echoes as 0x5A).
- Config latch: cpol toggled during SHIFT:
  - sclk level and sampling are unchanged until IDLE;
  - the next frame uses the new cpol.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_pkg;

  localparam int SPI_DATAWIDTH = 8;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LEAD,
    SHIFT,
    PUSH,
    TRAIL
  } spi_state_t;

endpackage

// File: rtl/spi_clk_divider.sv
// Reload down-counter producing one tick every (reload+1) enabled cycles.
module spi_clk_divider
  import spi_pkg::*;
#(
  parameter int DIVWIDTH = 8
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                i_load,
  input  logic                i_en,
  input  logic [DIVWIDTH-1:0] i_reload,
  output logic                o_tick
);

  logic [DIVWIDTH-1:0] r_cnt;

  // The tick is combinational so the consumer acts on the same edge the counter reloads.
  assign o_tick = i_en && (r_cnt == '0);

  // Count down while enabled; reload on request or whenever a tick fires.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= i_reload;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops TX bytes, shifts them out MSB first while
// capturing MISO, pushes captured bytes to RX, and owns SCLK and ssN.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATAWIDTH = SPI_DATAWIDTH,
  parameter int DIVWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIVWIDTH-1:0]  clkDiv,
  input  logic                 txEmpty,
  input  logic [DATAWIDTH-1:0] txData,
  output logic                 txReadReq,
  input  logic                 rxFull,
  output logic                 rxWriteEn,
  output logic [DATAWIDTH-1:0] rxData,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ssN,
  output logic                 busy
);

  localparam int EDGES = 2 * DATAWIDTH;
  localparam int CW    = $clog2(EDGES + 1);

  spi_state_t r_state, w_next;

  logic [1:0]           r_mode;
  logic [DIVWIDTH-1:0]  r_div;
  logic [DATAWIDTH-1:0] r_shift, r_rx, r_rx_data;
  logic [DATAWIDTH-1:0] w_rx_nxt;
  logic [CW-1:0]        r_edge, w_edge_nxt;
  logic r_sclk, r_mosi, r_ssn, r_busy, r_tx_rd, r_rx_we;
  logic w_tick, w_start, w_last, w_sample, w_div_load, w_div_en;
  logic w_cpol, w_cpha;

  assign w_start    = enable && !txEmpty && !rxFull;
  assign w_edge_nxt = r_edge + 1'b1;
  assign w_last     = (w_edge_nxt == CW'(EDGES));
  // Odd edges sample in cpha=0, even edges sample in cpha=1.
  assign w_sample   = w_edge_nxt[0] ^ w_cpha;
  assign w_rx_nxt   = {r_rx[DATAWIDTH-2:0], miso};
  // Divider is primed in every single-cycle state so each timed state starts a full half-period.
  assign w_div_load = r_state inside {IDLE, LOAD, PUSH};
  assign w_div_en   = r_state inside {LEAD, SHIFT, TRAIL};

  spi_clk_divider #(.DIVWIDTH(DIVWIDTH)) u_div (
    .clk      (clk),
    .resetN   (resetN),
    .i_load   (w_div_load),
    .i_en     (w_div_en),
    .i_reload (r_div),
    .o_tick   (w_tick)
  );

  // Decode the mode latched at burst start.
  always_comb begin
    w_cpol = 1'b0;
    w_cpha = 1'b0;
    case (r_mode)
      MODE0:   begin w_cpol = 1'b0; w_cpha = 1'b0; end
      MODE1:   begin w_cpol = 1'b0; w_cpha = 1'b1; end
      MODE2:   begin w_cpol = 1'b1; w_cpha = 1'b0; end
      MODE3:   begin w_cpol = 1'b1; w_cpha = 1'b1; end
      default: begin w_cpol = 1'b0; w_cpha = 1'b0; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = LOAD;
      LOAD:    w_next = r_ssn ? LEAD : SHIFT;
      LEAD:    if (w_tick) w_next = SHIFT;
      SHIFT:   if (w_tick && w_last) w_next = PUSH;
      PUSH:    w_next = w_start ? LOAD : TRAIL;
      TRAIL:   if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs, config latch and shift datapath.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mode    <= MODE0;
      r_div     <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_edge    <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ssn     <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_rd   <= 1'b0;
      r_rx_we   <= 1'b0;
    end else begin
      // LOAD and PUSH never repeat, so these strobes last exactly one cycle.
      r_tx_rd <= (w_next == LOAD);
      r_rx_we <= (w_next == PUSH);
      r_busy  <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          r_sclk <= cpol;
          if (w_start) begin
            r_mode <= {cpol, cpha};
            r_div  <= clkDiv;
          end
        end
        LOAD: begin
          r_shift <= txData;
          r_mosi  <= txData[DATAWIDTH-1];
          r_sclk  <= w_cpol;
          r_ssn   <= 1'b0;
          r_edge  <= '0;
        end
        SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= w_edge_nxt;
            if (w_sample) begin
              r_rx <= w_rx_nxt;
              if (w_cpha) r_shift <= {r_shift[DATAWIDTH-2:0], 1'b0};
            end else if (w_cpha) begin
              r_mosi <= r_shift[DATAWIDTH-1];
            end else if (!w_last) begin
              r_shift <= {r_shift[DATAWIDTH-2:0], 1'b0};
              r_mosi  <= r_shift[DATAWIDTH-2];
            end
            // Present the byte together with the push strobe.
            if (w_last) r_rx_data <= w_sample ? w_rx_nxt : r_rx;
          end
        end
        TRAIL: begin
          if (w_tick) r_ssn <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign txReadReq = r_tx_rd;
  assign rxWriteEn = r_rx_we;
  assign rxData    = r_rx_data;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign ssN       = r_ssn;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed/randomized bench for spi_shift_engine with a behavioural SPI slave,
// TX FIFO model and RX scoreboard.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       resetN, enable, cpol, cpha;
  logic [7:0] clkDiv;
  logic       txEmpty, rxFull, miso;
  logic [7:0] txData;
  logic       txReadReq, rxWriteEn, sclk, mosi, ssN, busy;
  logic [7:0] rxData;

  always #5 clk = ~clk;

  spi_shift_engine #(.DATAWIDTH(8), .DIVWIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .cpol(cpol), .cpha(cpha),
    .clkDiv(clkDiv), .txEmpty(txEmpty), .txData(txData), .txReadReq(txReadReq),
    .rxFull(rxFull), .rxWriteEn(rxWriteEn), .rxData(rxData), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ssN(ssN), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] slave_rx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_mosi[$];

  int pops, pushes, edges, ssn_falls, ssn_rises, viol_tx, viol_rx, lead_gap, fall_cyc;
  int rises[$];
  bit pop_pending, want_lead;
  logic m_sclk, m_ssn, sclk_at_rise;

  bit   loop;
  int   s_e, s_fidx;
  bit   s_loaded;
  logic [7:0] s_sb, s_srx;
  logic s_prev_sclk, s_prev_mosi, s_miso, s_cpha;

  assign miso = loop ? mosi : s_miso;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_tx();
    txEmpty = (tx_q.size() == 0);
    txData  = txEmpty ? 8'h00 : tx_q[0];
  endtask

  // SPI slave: counts SCLK edges while selected, samples/drives per its cpha.
  task automatic slave_step();
    if (ssN !== 1'b0) begin
      s_e = 0;
      s_loaded = 1'b0;
    end else begin
      if (!s_loaded) begin
        s_sb = (s_fidx < slave_q.size()) ? slave_q[s_fidx] : 8'h00;
        s_loaded = 1'b1;
        if (s_cpha == 1'b0) s_miso = s_sb[7];
      end
      if (sclk !== s_prev_sclk) begin
        s_e++;
        if (((s_e % 2) == 1) == (s_cpha == 1'b0)) begin
          s_srx = {s_srx[6:0], s_prev_mosi};
        end else if (s_cpha == 1'b1) begin
          s_miso = s_sb[7];
          s_sb   = s_sb << 1;
        end else begin
          s_sb   = s_sb << 1;
          s_miso = s_sb[7];
        end
        if (s_e == 16) begin
          slave_rx.push_back(s_srx);
          s_fidx++;
          s_e = 0;
          s_loaded = 1'b0;
        end
      end
    end
    s_prev_sclk = sclk;
    s_prev_mosi = mosi;
  endtask

  // Monitor at the falling clock edge: FIFO pops, pushes, SCLK/ssN activity.
  task automatic mon_step();
    cyc++;
    if (pop_pending && tx_q.size() > 0) begin
      void'(tx_q.pop_front());
      update_tx();
    end
    pop_pending = (txReadReq === 1'b1);
    if (txReadReq === 1'b1) begin
      pops++;
      if (txEmpty) viol_tx++;
    end
    if (rxWriteEn === 1'b1) begin
      pushes++;
      rx_got.push_back(rxData);
      if (rxFull) viol_rx++;
    end
    if (sclk !== m_sclk && ssN === 1'b0) begin
      edges++;
      if (sclk === 1'b1) rises.push_back(cyc);
      if (want_lead) begin
        lead_gap  = cyc - fall_cyc;
        want_lead = 1'b0;
      end
    end
    if (ssN === 1'b0 && m_ssn === 1'b1) begin
      ssn_falls++;
      fall_cyc  = cyc;
      want_lead = 1'b1;
    end
    if (ssN === 1'b1 && m_ssn === 1'b0) begin
      ssn_rises++;
      sclk_at_rise = sclk;
    end
    m_sclk = sclk;
    m_ssn  = ssN;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    slave_step();
    @(negedge clk);
    mon_step();
  endtask

  task automatic clear();
    pops = 0; pushes = 0; edges = 0; ssn_falls = 0; ssn_rises = 0; lead_gap = -1;
    rises.delete(); rx_got.delete(); slave_rx.delete(); slave_q.delete();
    exp_rx.delete(); exp_mosi.delete(); s_fidx = 0;
  endtask

  task automatic wait_push(input int n, input int budget, input string tag);
    int k = 0;
    while (pushes < n && k < budget) begin tick(); k++; end
    chk({tag, "_push_to"}, 32'(pushes >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((busy !== 1'b0 || ssN !== 1'b1) && k < budget) begin tick(); k++; end
    chk({tag, "_idle_to"}, 32'(busy === 1'b0 && ssN === 1'b1), 32'd1);
  endtask

  task automatic wait_edges(input int n, input int budget, input string tag);
    int k = 0;
    while (edges < n && k < budget) begin tick(); k++; end
    chk({tag, "_edge_to"}, 32'(edges >= n), 32'd1);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rx_n"}, 32'(rx_got.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
      chk({tag, "_rx"}, 32'(rx_got[i]), 32'(exp_rx[i]));
    chk({tag, "_mosi_n"}, 32'(slave_rx.size()), 32'(exp_mosi.size()));
    for (int i = 0; i < exp_mosi.size() && i < slave_rx.size(); i++)
      chk({tag, "_mosi"}, 32'(slave_rx[i]), 32'(exp_mosi[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_ssN"}, 32'(ssN), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_txrd"}, 32'(txReadReq), 32'd0);
    chk({tag, "_rxwe"}, 32'(rxWriteEn), 32'd0);
    chk({tag, "_rxdata"}, 32'(rxData), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    tx_q.push_back(b);
    exp_mosi.push_back(b);
    if (loop) exp_rx.push_back(b);
    update_tx();
  endtask

  task automatic slave_byte(input logic [7:0] b);
    slave_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] b1, b2;
    resetN = 1'b0; enable = 1'b0; cpol = 1'b0; cpha = 1'b0; clkDiv = 8'd1;
    rxFull = 1'b0; loop = 1'b1; s_cpha = 1'b0; s_miso = 1'b0; s_e = 0; s_fidx = 0;
    s_loaded = 1'b0; s_sb = 8'h00; s_srx = 8'h00; s_prev_sclk = 1'b0; s_prev_mosi = 1'b0;
    pop_pending = 1'b0; want_lead = 1'b0; viol_tx = 0; viol_rx = 0; fall_cyc = 0;
    m_sclk = 1'b0; m_ssn = 1'b1; sclk_at_rise = 1'b0;
    clear();
    update_tx();
    repeat (3) tick();
    check_reset_outputs("rst");
    resetN = 1'b1;
    repeat (3) tick();

    // Mode 0 loopback single frame
    clear(); loop = 1'b1; s_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0; clkDiv = 8'd1;
    send(8'hA5);
    enable = 1'b1;
    wait_push(1, 300, "t1");
    wait_idle(100, "t1");
    chk("t1_pops", 32'(pops), 32'd1);
    check_rx("t1");
    chk("t1_rises", 32'(rises.size()), 32'd8);
    bad = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 4) bad++;
    chk("t1_period", 32'(bad), 32'd0);
    chk("t1_lead", 32'(lead_gap), 32'd4);
    chk("t1_sclk_idle", 32'(sclk), 32'd0);

    // Mode 3 burst of three frames against a slave
    clear(); enable = 1'b0; loop = 1'b0; s_cpha = 1'b1; cpol = 1'b1; cpha = 1'b1;
    clkDiv = 8'($urandom_range(0, 3));
    slave_byte(8'h3C); slave_byte(8'hC3); slave_byte(8'h5A);
    send(8'h01); send(8'h80); send(8'hFF);
    tick(); tick();
    chk("t2_idle_hi", 32'(sclk), 32'd1);
    enable = 1'b1;
    wait_push(3, 1500, "t2");
    wait_idle(200, "t2");
    chk("t2_edges", 32'(edges), 32'd48);
    chk("t2_ssn_falls", 32'(ssn_falls), 32'd1);
    chk("t2_ssn_rises", 32'(ssn_rises), 32'd1);
    chk("t2_sclk_end", 32'(sclk_at_rise), 32'd1);
    check_rx("t2");

    // RX back-pressure holds off the frame
    clear(); rxFull = 1'b1; loop = 1'b1; s_cpha = 1'b1; cpol = 1'b0; cpha = 1'b1;
    clkDiv = 8'($urandom_range(0, 2));
    send(8'($urandom));
    repeat (20) tick();
    chk("t3_no_pop", 32'(pops), 32'd0);
    chk("t3_no_ss", 32'(ssn_falls), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    rxFull = 1'b0;
    n = 0;
    while (txReadReq !== 1'b1 && n < 10) begin tick(); n++; end
    chk("t3_start_lat", 32'(n >= 1 && n <= 2), 32'd1);
    wait_push(1, 300, "t3");
    wait_idle(100, "t3");
    check_rx("t3");
    chk("t3_rx_ovf", 32'(viol_rx), 32'd0);

    // Stall mid-burst: frame 1 pushed, TRAIL, frame 2 as a new burst
    clear(); loop = 1'b1; s_cpha = 1'b0; cpol = 1'b1; cpha = 1'b0; clkDiv = 8'd2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    send(b1); send(b2);
    wait_edges(4, 300, "t4");
    rxFull = 1'b1;
    wait_push(1, 300, "t4a");
    wait_idle(100, "t4a");
    chk("t4_push1", 32'(pushes), 32'd1);
    chk("t4_pops1", 32'(pops), 32'd1);
    chk("t4_rises1", 32'(ssn_rises), 32'd1);
    chk("t4_sclk_end", 32'(sclk_at_rise), 32'd1);
    repeat (15) tick();
    chk("t4_hold_push", 32'(pushes), 32'd1);
    chk("t4_hold_ss", 32'(ssn_falls), 32'd1);
    rxFull = 1'b0;
    wait_push(2, 400, "t4b");
    wait_idle(100, "t4b");
    chk("t4_falls2", 32'(ssn_falls), 32'd2);
    chk("t4_lead2", 32'(lead_gap), 32'd6);
    chk("t4_pops2", 32'(pops), 32'd2);
    check_rx("t4");

    // Reset mid-frame
    clear(); loop = 1'b1; s_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0; clkDiv = 8'd1;
    tx_q.push_back(8'($urandom)); update_tx();
    wait_edges(5, 300, "t5");
    resetN = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    repeat (4) tick();
    chk("t5_no_push", 32'(pushes), 32'd0);
    resetN = 1'b1;
    repeat (2) tick();
    clear();
    send(8'h5A);
    wait_push(1, 300, "t5");
    wait_idle(100, "t5");
    check_rx("t5");

    // cpol/cpha changed during SHIFT only affect the next frame
    clear(); loop = 1'b0; s_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0; clkDiv = 8'd2;
    slave_byte(8'($urandom)); send(8'($urandom));
    wait_edges(3, 300, "t6");
    cpol = 1'b1; cpha = 1'b1;
    wait_push(1, 300, "t6a");
    wait_idle(100, "t6a");
    chk("t6_edges1", 32'(edges), 32'd16);
    chk("t6_sclk_end1", 32'(sclk_at_rise), 32'd0);
    check_rx("t6a");
    tick();
    chk("t6_new_idle", 32'(sclk), 32'd1);
    clear(); s_cpha = 1'b1;
    slave_byte(8'($urandom)); send(8'($urandom));
    wait_push(1, 300, "t6b");
    wait_idle(100, "t6b");
    chk("t6_edges2", 32'(edges), 32'd16);
    chk("t6_sclk_end2", 32'(sclk_at_rise), 32'd1);
    check_rx("t6b");

    chk("tx_underflow", 32'(viol_tx), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
